// File: rtl/bp_me_pkg.sv
// Shared types for the config responder: IO memory message layout, register
// offsets, responder FSM states and processor-configuration widths.
package bp_me_pkg;

    localparam int paddr_width_p           = 40;
    localparam int core_id_width_p         = 4;
    localparam int io_noc_did_width_p      = 4;
    localparam int num_cce_instr_ram_els_p = 256;
    localparam int cce_instr_ram_addr_width_lp = $clog2(num_cce_instr_ram_els_p);
    localparam int mem_payload_width_lp    = 16;

    localparam logic [15:0] instr_ram_base_default_lp = 16'h8000;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_wb    = 4'd4,
        e_cce_mem_pre   = 4'd5
    } bp_cce_mem_msg_type_e;

    typedef struct packed {
        bp_cce_mem_msg_type_e            msg_type;
        logic [paddr_width_p-1:0]        addr;
        logic [2:0]                      size;
        logic [mem_payload_width_lp-1:0] payload;
        logic [63:0]                     data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef enum logic [15:0] {
        e_cfg_freeze   = 16'h0000,
        e_cfg_core_id  = 16'h0008,
        e_cfg_did      = 16'h0010,
        e_cfg_cce_mode = 16'h0018
    } bp_cfg_reg_e;

    typedef enum logic [1:0] {
        e_ready    = 2'd0,
        e_ram_wait = 2'd1,
        e_send     = 2'd2
    } bp_cfg_state_e;

    // Compact register select codes produced by the decoder.
    localparam logic [1:0] sel_freeze_lp   = 2'd0;
    localparam logic [1:0] sel_core_id_lp  = 2'd1;
    localparam logic [1:0] sel_did_lp      = 2'd2;
    localparam logic [1:0] sel_cce_mode_lp = 2'd3;

endpackage

// File: rtl/bp_me_cfg_responder_decode.sv
// Combinational decode of a config-space offset and message type into a
// register select, an instruction-RAM hit with its index, or unmapped.
module bp_me_cfg_decode
    import bp_me_pkg::*;
#(
    parameter logic [15:0] instr_ram_base_p = instr_ram_base_default_lp,
    parameter int          num_els_p        = num_cce_instr_ram_els_p,
    localparam int         idx_w_lp         = $clog2(num_els_p)
) (
    input  logic [3:0]          msg_type_i,
    input  logic [15:0]         offset_i,
    output logic                is_wr_o,
    output logic                reg_hit_o,
    output logic [1:0]          reg_sel_o,
    output logic                ram_hit_o,
    output logic [idx_w_lp-1:0] ram_idx_o,
    output logic                unmapped_o
);

    localparam logic [16:0] win_bytes_lp = 17'(num_els_p * 8);

    logic        is_uc;
    logic        reg_match;
    logic [16:0] rel;
    logic        in_win;

    assign is_uc   = (msg_type_i == e_cce_mem_uc_rd) || (msg_type_i == e_cce_mem_uc_wr);
    assign is_wr_o = (msg_type_i == e_cce_mem_uc_wr);

    always_comb begin
        reg_match = 1'b1;
        reg_sel_o = sel_freeze_lp;
        case (offset_i)
            e_cfg_freeze:   reg_sel_o = sel_freeze_lp;
            e_cfg_core_id:  reg_sel_o = sel_core_id_lp;
            e_cfg_did:      reg_sel_o = sel_did_lp;
            e_cfg_cce_mode: reg_sel_o = sel_cce_mode_lp;
            default:        reg_match = 1'b0;
        endcase
    end

    // A 17-bit difference makes offsets below the window base show up as negative.
    assign rel    = {1'b0, offset_i} - {1'b0, instr_ram_base_p};
    assign in_win = !rel[16] && (rel < win_bytes_lp);

    assign ram_idx_o  = rel[idx_w_lp+2:3];
    assign reg_hit_o  = is_uc && reg_match;
    assign ram_hit_o  = is_uc && !reg_match && in_win;
    assign unmapped_o = !(reg_hit_o || ram_hit_o);

endmodule

// File: rtl/bp_me_cfg_responder.sv
// Config-space responder: consumes one uncached IO command at a time, updates
// or reads the tile control registers or the CCE instruction RAM, and replies.
module bp_me_cfg_responder
    import bp_me_pkg::*;
#(
    parameter logic [15:0] instr_ram_base_p = instr_ram_base_default_lp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [cce_mem_msg_width_lp-1:0]        io_cmd_i,
    input  logic                                   io_cmd_v_i,
    output logic                                   io_cmd_yumi_o,
    output logic [cce_mem_msg_width_lp-1:0]        io_resp_o,
    output logic                                   io_resp_v_o,
    input  logic                                   io_resp_ready_i,
    output logic                                   freeze_o,
    output logic [core_id_width_p-1:0]             core_id_o,
    output logic [io_noc_did_width_p-1:0]          did_o,
    output logic                                   cce_mode_o,
    output logic                                   instr_w_v_o,
    output logic                                   instr_r_v_o,
    output logic [cce_instr_ram_addr_width_lp-1:0] instr_addr_o,
    output logic [63:0]                            instr_data_o,
    input  logic [63:0]                            instr_data_i,
    output logic [1:0]                             state_o
);

    // Handshakes: a command transfers on a clock edge where io_cmd_v_i and
    // io_cmd_yumi_o are both high; a response transfers where io_resp_v_o and
    // io_resp_ready_i are both high. io_resp_o is held until it transfers.

    bp_cce_mem_msg_s cmd;
    bp_cce_mem_msg_s resp_q, resp_d;
    bp_cfg_state_e   state_q, state_d;

    logic                              freeze_q, freeze_d;
    logic [core_id_width_p-1:0]        core_id_q, core_id_d;
    logic [io_noc_did_width_p-1:0]     did_q, did_d;
    logic                              cce_mode_q, cce_mode_d;

    logic                                   dec_is_wr;
    logic                                   dec_reg_hit;
    logic [1:0]                             dec_reg_sel;
    logic                                   dec_ram_hit;
    logic [cce_instr_ram_addr_width_lp-1:0] dec_ram_idx;
    logic                                   dec_unmapped;
    logic [63:0]                            reg_rdata;

    assign cmd = io_cmd_i;

    bp_me_cfg_decode #(
        .instr_ram_base_p (instr_ram_base_p),
        .num_els_p        (num_cce_instr_ram_els_p)
    ) decode (
        .msg_type_i (cmd.msg_type),
        .offset_i   (cmd.addr[15:0]),
        .is_wr_o    (dec_is_wr),
        .reg_hit_o  (dec_reg_hit),
        .reg_sel_o  (dec_reg_sel),
        .ram_hit_o  (dec_ram_hit),
        .ram_idx_o  (dec_ram_idx),
        .unmapped_o (dec_unmapped)
    );

    always_comb begin
        reg_rdata = '0;
        case (dec_reg_sel)
            sel_freeze_lp:   reg_rdata = 64'(freeze_q);
            sel_core_id_lp:  reg_rdata = 64'(core_id_q);
            sel_did_lp:      reg_rdata = 64'(did_q);
            default:         reg_rdata = 64'(cce_mode_q);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        resp_d        = resp_q;
        freeze_d      = freeze_q;
        core_id_d     = core_id_q;
        did_d         = did_q;
        cce_mode_d    = cce_mode_q;
        io_cmd_yumi_o = 1'b0;
        io_resp_v_o   = 1'b0;
        instr_w_v_o   = 1'b0;
        instr_r_v_o   = 1'b0;
        instr_addr_o  = '0;

        case (state_q)
            e_ready: begin
                io_cmd_yumi_o = io_cmd_v_i;
                if (io_cmd_v_i) begin
                    resp_d      = cmd;
                    resp_d.data = '0;
                    state_d     = e_send;
                    if (dec_unmapped) begin
                        // Unmapped or cached accesses only get an empty reply.
                    end else if (dec_ram_hit) begin
                        instr_addr_o = dec_ram_idx;
                        if (dec_is_wr) begin
                            instr_w_v_o = 1'b1;
                        end else begin
                            instr_r_v_o = 1'b1;
                            state_d     = e_ram_wait;
                        end
                    end else if (dec_is_wr) begin
                        case (dec_reg_sel)
                            sel_freeze_lp:  freeze_d  = cmd.data[0];
                            sel_core_id_lp: core_id_d = cmd.data[core_id_width_p-1:0];
                            sel_did_lp:     did_d     = cmd.data[io_noc_did_width_p-1:0];
                            default:        cce_mode_d = cmd.data[0];
                        endcase
                    end else begin
                        resp_d.data = reg_rdata;
                    end
                end
            end
            e_ram_wait: begin
                resp_d.data = instr_data_i;
                state_d     = e_send;
            end
            e_send: begin
                io_resp_v_o = 1'b1;
                if (io_resp_ready_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_ready;
            resp_q     <= '0;
            freeze_q   <= 1'b1;
            core_id_q  <= '0;
            did_q      <= '0;
            cce_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            freeze_q   <= freeze_d;
            core_id_q  <= core_id_d;
            did_q      <= did_d;
            cce_mode_q <= cce_mode_d;
        end
    end

    assign io_resp_o    = resp_q;
    assign instr_data_o = cmd.data;
    assign freeze_o     = freeze_q;
    assign core_id_o    = core_id_q;
    assign did_o        = did_q;
    assign cce_mode_o   = cce_mode_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_bp_me_cfg_responder.sv
// Directed bench for bp_me_cfg_responder: a vector table of single commands,
// then backpressure and reset-abort sequences, with a small external RAM.
module tb_bp_me_cfg_responder;
    import bp_me_pkg::*;

    logic                                   clk;
    logic                                   reset_i;
    logic [cce_mem_msg_width_lp-1:0]        io_cmd_i;
    logic                                   io_cmd_v_i;
    logic                                   io_cmd_yumi_o;
    logic [cce_mem_msg_width_lp-1:0]        io_resp_o;
    logic                                   io_resp_v_o;
    logic                                   io_resp_ready_i;
    logic                                   freeze_o;
    logic [core_id_width_p-1:0]             core_id_o;
    logic [io_noc_did_width_p-1:0]          did_o;
    logic                                   cce_mode_o;
    logic                                   instr_w_v_o;
    logic                                   instr_r_v_o;
    logic [cce_instr_ram_addr_width_lp-1:0] instr_addr_o;
    logic [63:0]                            instr_data_o;
    logic [63:0]                            instr_data_i = '0;
    logic [1:0]                             state_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_me_cfg_responder dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .io_cmd_i        (io_cmd_i),
        .io_cmd_v_i      (io_cmd_v_i),
        .io_cmd_yumi_o   (io_cmd_yumi_o),
        .io_resp_o       (io_resp_o),
        .io_resp_v_o     (io_resp_v_o),
        .io_resp_ready_i (io_resp_ready_i),
        .freeze_o        (freeze_o),
        .core_id_o       (core_id_o),
        .did_o           (did_o),
        .cce_mode_o      (cce_mode_o),
        .instr_w_v_o     (instr_w_v_o),
        .instr_r_v_o     (instr_r_v_o),
        .instr_addr_o    (instr_addr_o),
        .instr_data_o    (instr_data_o),
        .instr_data_i    (instr_data_i),
        .state_o         (state_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External instruction RAM with one-cycle read latency
    logic [63:0] ram_mem [num_cce_instr_ram_els_p];
    always @(posedge clk) begin
        if (instr_w_v_o) ram_mem[instr_addr_o] <= instr_data_o;
        if (instr_r_v_o) instr_data_i <= ram_mem[instr_addr_o];
    end

    typedef struct {
        bp_cce_mem_msg_type_e mt;
        logic [39:0]          addr;
        logic [63:0]          data;
        logic [63:0]          exp_data;
        logic                 exp_w;
        logic                 exp_r;
        logic [7:0]           exp_idx;
        int                   exp_lat;
        logic                 exp_freeze;
        logic [3:0]           exp_core;
        logic [3:0]           exp_did;
        logic                 exp_mode;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bp_cce_mem_msg_type_e mt, input logic [39:0] addr,
                                input logic [63:0] data, input logic [63:0] exp_data,
                                input logic exp_w, input logic exp_r, input logic [7:0] exp_idx,
                                input int exp_lat, input logic f, input logic [3:0] c,
                                input logic [3:0] d, input logic m);
        vec_t v;
        v.mt = mt; v.addr = addr; v.data = data; v.exp_data = exp_data;
        v.exp_w = exp_w; v.exp_r = exp_r; v.exp_idx = exp_idx; v.exp_lat = exp_lat;
        v.exp_freeze = f; v.exp_core = c; v.exp_did = d; v.exp_mode = m;
        return v;
    endfunction

    // Driver: one command through accept, response wait and handshake
    task automatic run_vec(input int k, input vec_t v);
        bp_cce_mem_msg_s c;
        bp_cce_mem_msg_s r;
        int lat;
        c.msg_type = v.mt;
        c.addr     = v.addr;
        c.size     = 3'd3;
        c.payload  = 16'(16'h100 + k);
        c.data     = v.data;
        @(negedge clk);
        io_cmd_i   = c;
        io_cmd_v_i = 1'b1;
        #1;
        chk($sformatf("v%0d_yumi", k), 128'(io_cmd_yumi_o), 128'(1'b1));
        chk($sformatf("v%0d_wv", k), 128'(instr_w_v_o), 128'(v.exp_w));
        chk($sformatf("v%0d_rv", k), 128'(instr_r_v_o), 128'(v.exp_r));
        if (v.exp_w || v.exp_r)
            chk($sformatf("v%0d_idx", k), 128'(instr_addr_o), 128'(v.exp_idx));
        if (v.exp_w)
            chk($sformatf("v%0d_wdata", k), 128'(instr_data_o), 128'(v.data));
        @(posedge clk);
        #1 io_cmd_v_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!io_resp_v_o && lat < 8);
        chk($sformatf("v%0d_lat", k), 128'(lat), 128'(v.exp_lat));
        r = io_resp_o;
        chk($sformatf("v%0d_rdata", k), 128'(r.data), 128'(v.exp_data));
        chk($sformatf("v%0d_raddr", k), 128'(r.addr), 128'(v.addr));
        chk($sformatf("v%0d_rpay", k), 128'(r.payload), 128'(c.payload));
        chk($sformatf("v%0d_rtype", k), 128'(r.msg_type), 128'(v.mt));
        chk($sformatf("v%0d_rsize", k), 128'(r.size), 128'(3'd3));
        chk($sformatf("v%0d_freeze", k), 128'(freeze_o), 128'(v.exp_freeze));
        chk($sformatf("v%0d_core", k), 128'(core_id_o), 128'(v.exp_core));
        chk($sformatf("v%0d_did", k), 128'(did_o), 128'(v.exp_did));
        chk($sformatf("v%0d_mode", k), 128'(cce_mode_o), 128'(v.exp_mode));
        @(posedge clk);
    endtask

    initial begin
        bp_cce_mem_msg_s cmd_a, cmd_b, exp_a, r;

        reset_i         = 1'b1;
        io_cmd_i        = '0;
        io_cmd_v_i      = 1'b0;
        io_resp_ready_i = 1'b1;

        //           type             addr            data                    exp_data                w  r  idx    lat f  core  did   m
        vecs[0]  = mk(e_cce_mem_uc_wr, 40'h0008,      64'h3,                  64'h0,                  0, 0, 8'd0,   1, 1, 4'd3, 4'd0, 0);
        vecs[1]  = mk(e_cce_mem_uc_wr, 40'h0000,      64'h0,                  64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd0, 0);
        vecs[2]  = mk(e_cce_mem_uc_wr, 40'h0010,      64'hA5,                 64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 0);
        vecs[3]  = mk(e_cce_mem_uc_wr, 40'h0018,      64'hFF,                 64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[4]  = mk(e_cce_mem_uc_rd, 40'h0008,      64'h0,                  64'h3,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[5]  = mk(e_cce_mem_uc_rd, 40'h0010,      64'h0,                  64'h5,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[6]  = mk(e_cce_mem_uc_wr, 40'h8010,      64'hDEADBEEF_CAFEF00D,  64'h0,                  1, 0, 8'd2,   1, 0, 4'd3, 4'd5, 1);
        vecs[7]  = mk(e_cce_mem_uc_rd, 40'h8010,      64'h0,                  64'hDEADBEEF_CAFEF00D,  0, 1, 8'd2,   2, 0, 4'd3, 4'd5, 1);
        vecs[8]  = mk(e_cce_mem_uc_rd, 40'h0100,      64'h0,                  64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[9]  = mk(e_cce_mem_uc_wr, 40'h87F8,      64'h1234,               64'h0,                  1, 0, 8'd255, 1, 0, 4'd3, 4'd5, 1);
        vecs[10] = mk(e_cce_mem_uc_rd, 40'h87F8,      64'h0,                  64'h1234,               0, 1, 8'd255, 2, 0, 4'd3, 4'd5, 1);
        vecs[11] = mk(e_cce_mem_uc_wr, 40'h8800,      64'h55,                 64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[12] = mk(e_cce_mem_wr,    40'h0000,      64'h1,                  64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[13] = mk(e_cce_mem_uc_rd, 40'h0000,      64'h0,                  64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[14] = mk(e_cce_mem_uc_rd, 40'h0018,      64'h0,                  64'h1,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[15] = mk(e_cce_mem_uc_rd, 40'h10_0000_0008, 64'h0,               64'h3,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);
        vecs[16] = mk(e_cce_mem_uc_wr, 40'h0004,      64'h7,                  64'h0,                  0, 0, 8'd0,   1, 0, 4'd3, 4'd5, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;

        // Idle after reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_freeze", 128'(freeze_o), 128'(1'b1));
            chk("idle_core", 128'(core_id_o), 128'(4'd0));
            chk("idle_resp_v", 128'(io_resp_v_o), 128'(1'b0));
            chk("idle_state", 128'(state_o), 128'(e_ready));
        end

        for (int k = 0; k < 17; k++) run_vec(k, vecs[k]);

        // Backpressure with a second command waiting
        cmd_a.msg_type = e_cce_mem_uc_rd; cmd_a.addr = 40'h0010; cmd_a.size = 3'd3;
        cmd_a.payload  = 16'hBEEF;        cmd_a.data = 64'h0;
        cmd_b.msg_type = e_cce_mem_uc_rd; cmd_b.addr = 40'h0008; cmd_b.size = 3'd2;
        cmd_b.payload  = 16'hCAFE;        cmd_b.data = 64'h0;
        exp_a = cmd_a;
        exp_a.data = 64'h5;
        @(negedge clk);
        io_resp_ready_i = 1'b0;
        io_cmd_i        = cmd_a;
        io_cmd_v_i      = 1'b1;
        #1 chk("bp_yumi_a", 128'(io_cmd_yumi_o), 128'(1'b1));
        @(posedge clk);
        #1 io_cmd_i = cmd_b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_v", 128'(io_resp_v_o), 128'(1'b1));
            chk("bp_yumi_hold", 128'(io_cmd_yumi_o), 128'(1'b0));
            chk("bp_resp", 128'(io_resp_o), 128'(exp_a));
        end
        io_resp_ready_i = 1'b1;
        #1 chk("bp_yumi_hs", 128'(io_cmd_yumi_o), 128'(1'b0));
        @(negedge clk);
        chk("bp_state_after", 128'(state_o), 128'(e_ready));
        chk("bp_yumi_b", 128'(io_cmd_yumi_o), 128'(1'b1));
        chk("bp_resp_v_gap", 128'(io_resp_v_o), 128'(1'b0));
        @(posedge clk);
        #1 io_cmd_v_i = 1'b0;
        @(negedge clk);
        r = io_resp_o;
        chk("bp_b_resp_v", 128'(io_resp_v_o), 128'(1'b1));
        chk("bp_b_data", 128'(r.data), 128'(64'h3));
        chk("bp_b_pay", 128'(r.payload), 128'(16'hCAFE));
        chk("bp_b_size", 128'(r.size), 128'(3'd2));
        @(posedge clk);

        // Reset while waiting on the RAM
        cmd_a.msg_type = e_cce_mem_uc_rd; cmd_a.addr = 40'h8010; cmd_a.payload = 16'h0777;
        @(negedge clk);
        io_cmd_i   = cmd_a;
        io_cmd_v_i = 1'b1;
        @(posedge clk);
        #1 io_cmd_v_i = 1'b0;
        @(negedge clk);
        chk("rst_in_wait", 128'(state_o), 128'(e_ram_wait));
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst_resp_v", 128'(io_resp_v_o), 128'(1'b0));
        chk("rst_freeze", 128'(freeze_o), 128'(1'b1));
        chk("rst_core", 128'(core_id_o), 128'(4'd0));
        chk("rst_did", 128'(did_o), 128'(4'd0));
        chk("rst_mode", 128'(cce_mode_o), 128'(1'b0));
        chk("rst_state", 128'(state_o), 128'(e_ready));
        reset_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_resp", 128'(io_resp_v_o), 128'(1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
